cam_search_engine: RTL and testbench

CAM_SEARCH_ENGINE -- requirements
Module: cam_search_engine

---
 rtl/cam_search_engine_pkg.sv | 21 ++
 rtl/cam_search_engine_priority_encoder.sv | 28 ++
 rtl/cam_search_engine.sv | 144 ++++++++++++++
 tb/tb_cam_search_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_search_engine_pkg.sv
// Shared CAM definitions: geometry defaults and the entry-array type used by
// both the search engine and the downstream word mux.
// No logic; sizes only.
// Contents: CAM_DEPTH, CAM_WIDTH, CAM_IDX_W, cam_word_t, cam_entries_t.
package cam_search_engine_pkg;

  // Number of CAM entries.
  localparam int CAM_DEPTH = 32;
  // Bits per entry and per search key.
  localparam int CAM_WIDTH = 32;
  // Index width, log2(CAM_DEPTH).
  localparam int CAM_IDX_W = 5;

  // One stored word.
  typedef logic [CAM_WIDTH-1:0] cam_word_t;

  // Whole entry array, DEPTH words of WIDTH bits. Index [i] selects entry i,
  // matching the layout of the engine's entries_o port.
  typedef cam_word_t [CAM_DEPTH-1:0] cam_entries_t;

endpackage : cam_search_engine_pkg

// File: rtl/cam_search_engine_priority_encoder.sv
// Lowest-index priority encoder for the CAM match vector.
// Latency: combinational.
// Backpressure: none.
// Ports: vec_i (DEPTH-bit match vector) in; hit_o (any bit set) and
//        index_o (lowest set bit, 0 when no bit set) out.
module cam_priority_encoder #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [DEPTH-1:0] vec_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] index_o
);

  // Scan from the top down so the last assignment made is for the lowest
  // set bit; the index stays 0 when nothing matches.
  always_comb begin
    hit_o   = 1'b0;
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        hit_o   = 1'b1;
        index_o = IDX_W'(i);
      end
    end
  end

endmodule : cam_priority_encoder

// File: rtl/cam_search_engine.sv
// Content-addressable search engine with write/invalidate port.
// Latency: 2 cycles from search acceptance to result_valid_o, 1 search/cycle.
// Backpressure: result_ready_i low stalls stage 2; search_ready_o drops only
//               when both stages are full and the result is not taken.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   wr_valid_i/wr_inval_i/wr_index_i/wr_data_i   entry load or invalidate
//   search_valid_i/search_ready_o/search_key_i   search request handshake
//   result_valid_o/result_ready_i/result_hit_o/result_index_o  result handshake
//   entries_o                       stored entry array for the downstream mux
//   count_o                         number of valid entries
module cam_search_engine
  import cam_search_engine_pkg::*;
#(
  parameter int DEPTH = CAM_DEPTH,
  parameter int WIDTH = CAM_WIDTH,
  parameter int IDX_W = CAM_IDX_W
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        wr_valid_i,
  input  logic                        wr_inval_i,
  input  logic [IDX_W-1:0]            wr_index_i,
  input  logic [WIDTH-1:0]            wr_data_i,

  input  logic                        search_valid_i,
  output logic                        search_ready_o,
  input  logic [WIDTH-1:0]            search_key_i,

  output logic                        result_valid_o,
  input  logic                        result_ready_i,
  output logic                        result_hit_o,
  output logic [IDX_W-1:0]            result_index_o,

  output logic [DEPTH-1:0][WIDTH-1:0] entries_o,
  output logic [IDX_W:0]              count_o
);

  // Entry storage.
  logic [DEPTH-1:0][WIDTH-1:0] r_entries;
  logic [DEPTH-1:0]            r_valid;
  logic [IDX_W:0]              r_count;

  // Stage 1: registered match vector.
  logic                        r_s1_vld;
  logic [DEPTH-1:0]            r_s1_match;

  // Stage 2: encoded result.
  logic                        r_s2_vld;
  logic                        r_s2_hit;
  logic [IDX_W-1:0]            r_s2_idx;

  logic [DEPTH-1:0]            w_match;
  logic                        w_s2_free;
  logic                        w_s1_adv;
  logic                        w_accept;
  logic                        w_wr_was_valid;
  logic                        w_enc_hit;
  logic [IDX_W-1:0]            w_enc_idx;

  // Stage 2 can take new data when empty or when its result leaves now.
  assign w_s2_free      = !r_s2_vld || result_ready_i;
  // Stage 1 can take a new search when empty or when it drains into stage 2.
  assign w_s1_adv       = !r_s1_vld || w_s2_free;
  assign search_ready_o = w_s1_adv;
  assign w_accept       = search_valid_i && w_s1_adv;

  // Compare against the registered array, so a write on the accepting edge
  // is not visible to this search.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_entries[i] == search_key_i);
    end
  end

  assign w_wr_was_valid = r_valid[wr_index_i];

  // Entry array, valid bits and occupancy count. The count tracks valid-bit
  // transitions only, so it always equals the number of set valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entries <= '0;
      r_valid   <= '0;
      r_count   <= '0;
    end else if (wr_valid_i) begin
      if (wr_inval_i) begin
        // Data is left in place; only the valid bit is cleared.
        r_valid[wr_index_i] <= 1'b0;
        if (w_wr_was_valid) begin
          r_count <= r_count - (IDX_W+1)'(1);
        end
      end else begin
        r_entries[wr_index_i] <= wr_data_i;
        r_valid[wr_index_i]   <= 1'b1;
        if (!w_wr_was_valid) begin
          r_count <= r_count + (IDX_W+1)'(1);
        end
      end
    end
  end

  cam_priority_encoder #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_prienc (
    .vec_i   (r_s1_match),
    .hit_o   (w_enc_hit),
    .index_o (w_enc_idx)
  );

  // Two-stage search pipeline. Stage 1 holds its match vector while stage 2
  // is stalled; stage 2 holds its result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_match <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_hit   <= 1'b0;
      r_s2_idx   <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_vld <= w_accept;
        if (w_accept) begin
          r_s1_match <= w_match;
        end
      end
      if (w_s2_free) begin
        r_s2_vld <= r_s1_vld;
        // A bubble loads a clean miss so idle outputs read as zero.
        r_s2_hit <= r_s1_vld && w_enc_hit;
        r_s2_idx <= r_s1_vld ? w_enc_idx : '0;
      end
    end
  end

  assign result_valid_o = r_s2_vld;
  assign result_hit_o   = r_s2_hit;
  assign result_index_o = r_s2_idx;
  assign entries_o      = r_entries;
  assign count_o        = r_count;

endmodule : cam_search_engine

// File: tb/tb_cam_search_engine.sv
module tb_cam_search_engine;

  localparam int DEPTH = 32;
  localparam int WIDTH = 32;
  localparam int IDX_W = 5;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        wr_valid_i;
  logic                        wr_inval_i;
  logic [IDX_W-1:0]            wr_index_i;
  logic [WIDTH-1:0]            wr_data_i;
  logic                        search_valid_i;
  logic                        search_ready_o;
  logic [WIDTH-1:0]            search_key_i;
  logic                        result_valid_o;
  logic                        result_ready_i;
  logic                        result_hit_o;
  logic [IDX_W-1:0]            result_index_o;
  logic [DEPTH-1:0][WIDTH-1:0] entries_o;
  logic [IDX_W:0]              count_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic             hit;
    logic [IDX_W-1:0] idx;
    int               acc;
  } exp_t;

  always #5 clk = ~clk;

  cam_search_engine #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_valid_i     (wr_valid_i),
    .wr_inval_i     (wr_inval_i),
    .wr_index_i     (wr_index_i),
    .wr_data_i      (wr_data_i),
    .search_valid_i (search_valid_i),
    .search_ready_o (search_ready_o),
    .search_key_i   (search_key_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_hit_o   (result_hit_o),
    .result_index_o (result_index_o),
    .entries_o      (entries_o),
    .count_o        (count_o)
  );

  task automatic idle();
    wr_valid_i     = 1'b0;
    wr_inval_i     = 1'b0;
    wr_index_i     = '0;
    wr_data_i      = '0;
    search_valid_i = 1'b0;
    search_key_i   = '0;
    result_ready_i = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_write(input logic inval, input int idx, input logic [WIDTH-1:0] dat);
    wr_valid_i = 1'b1;
    wr_inval_i = inval;
    wr_index_i = IDX_W'(idx);
    wr_data_i  = dat;
    tick();
    idle();
  endtask

  task automatic test_reset();
    logic ent_zero;
    rst_n = 1'b0;
    idle();
    #2;
    ent_zero = (entries_o == '0);
    n_checks++; if (result_valid_o !== 1'b0) $display("FAIL rst_valid: got %b want 0", result_valid_o); else n_pass++;
    n_checks++; if (result_hit_o !== 1'b0) $display("FAIL rst_hit: got %b want 0", result_hit_o); else n_pass++;
    n_checks++; if (result_index_o !== '0) $display("FAIL rst_index: got %0d want 0", result_index_o); else n_pass++;
    n_checks++; if (ent_zero !== 1'b1) $display("FAIL rst_entries: got nonzero want all zero"); else n_pass++;
    n_checks++; if (count_o !== '0) $display("FAIL rst_count: got %0d want 0", count_o); else n_pass++;
    n_checks++; if (search_ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", search_ready_o); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (result_valid_o !== 1'b0 || search_ready_o !== 1'b1 || count_o !== '0)
      $display("FAIL post_rst: valid=%b ready=%b count=%0d want 0/1/0", result_valid_o, search_ready_o, count_o);
    else n_pass++;
  endtask

  task automatic test_basic_hit();
    apply_reset();
    do_write(1'b0, 7, 32'hDEAD_BEEF);
    n_checks++; if (entries_o[7] !== 32'hDEAD_BEEF) $display("FAIL load_entry7: got %h want deadbeef", entries_o[7]); else n_pass++;
    search_valid_i = 1'b1;
    search_key_i   = 32'hDEAD_BEEF;
    tick();
    idle();
    n_checks++; if (result_valid_o !== 1'b0) $display("FAIL basic_lat1: got valid=%b want 0 after 1 cycle", result_valid_o); else n_pass++;
    tick();
    n_checks++; if (result_valid_o !== 1'b1) $display("FAIL basic_lat2: got valid=%b want 1 after 2 cycles", result_valid_o); else n_pass++;
    n_checks++; if (result_hit_o !== 1'b1 || result_index_o !== 5'd7)
      $display("FAIL basic_hit: got hit=%b idx=%0d want hit=1 idx=7", result_hit_o, result_index_o);
    else n_pass++;
    n_checks++; if (count_o !== 6'd1) $display("FAIL basic_count: got %0d want 1", count_o); else n_pass++;
    tick();
    n_checks++; if (result_valid_o !== 1'b0) $display("FAIL basic_drain: got valid=%b want 0", result_valid_o); else n_pass++;
  endtask

  task automatic test_priority_inval();
    apply_reset();
    do_write(1'b0, 3, 32'h0000_00AA);
    do_write(1'b0, 12, 32'h0000_00AA);
    search_valid_i = 1'b1;
    search_key_i   = 32'h0000_00AA;
    tick();
    idle();
    tick();
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b1 || result_index_o !== 5'd3)
      $display("FAIL prio_lowest: got v=%b hit=%b idx=%0d want 1/1/3", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
    n_checks++; if (count_o !== 6'd2) $display("FAIL prio_count2: got %0d want 2", count_o); else n_pass++;
    do_write(1'b1, 3, 32'hFFFF_FFFF);
    n_checks++; if (entries_o[3] !== 32'h0000_00AA) $display("FAIL inval_keeps_data: got %h want 000000aa", entries_o[3]); else n_pass++;
    n_checks++; if (count_o !== 6'd1) $display("FAIL inval_count: got %0d want 1", count_o); else n_pass++;
    do_write(1'b1, 3, 32'h0);
    n_checks++; if (count_o !== 6'd1) $display("FAIL reinval_count: got %0d want 1", count_o); else n_pass++;
    do_write(1'b0, 12, 32'h0000_00AA);
    n_checks++; if (count_o !== 6'd1) $display("FAIL reload_count: got %0d want 1", count_o); else n_pass++;
    search_valid_i = 1'b1;
    search_key_i   = 32'h0000_00AA;
    tick();
    idle();
    tick();
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b1 || result_index_o !== 5'd12)
      $display("FAIL prio_after_inval: got v=%b hit=%b idx=%0d want 1/1/12", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
  endtask

  task automatic test_empty_miss();
    apply_reset();
    search_valid_i = 1'b1;
    search_key_i   = 32'h1234_5678;
    tick();
    search_key_i   = 32'h0;
    tick();
    idle();
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b0 || result_index_o !== '0)
      $display("FAIL empty_miss: got v=%b hit=%b idx=%0d want 1/0/0", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
    tick();
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b0 || result_index_o !== '0)
      $display("FAIL zero_key_miss: got v=%b hit=%b idx=%0d want 1/0/0", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_write(1'b0, 2, 32'h0000_0011);
    do_write(1'b0, 9, 32'h0000_0022);
    result_ready_i = 1'b0;
    search_valid_i = 1'b1;
    search_key_i   = 32'h0000_0011;
    #1;
    n_checks++; if (search_ready_o !== 1'b1) $display("FAIL b2b_ready1: got %b want 1", search_ready_o); else n_pass++;
    tick();
    search_key_i = 32'h0000_0022;
    #1;
    n_checks++; if (search_ready_o !== 1'b1) $display("FAIL b2b_ready2: got %b want 1", search_ready_o); else n_pass++;
    tick();
    search_key_i = 32'h0000_0011;
    #1;
    n_checks++; if (search_ready_o !== 1'b0) $display("FAIL b2b_ready_low: got %b want 0", search_ready_o); else n_pass++;
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b1 || result_index_o !== 5'd2)
      $display("FAIL b2b_first: got v=%b hit=%b idx=%0d want 1/1/2", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
    tick();
    search_valid_i = 1'b0;
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b1 || result_index_o !== 5'd2)
      $display("FAIL b2b_hold: got v=%b hit=%b idx=%0d want 1/1/2", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
    result_ready_i = 1'b1;
    #1;
    n_checks++; if (search_ready_o !== 1'b1) $display("FAIL b2b_ready_back: got %b want 1", search_ready_o); else n_pass++;
    tick();
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b1 || result_index_o !== 5'd9)
      $display("FAIL b2b_second: got v=%b hit=%b idx=%0d want 1/1/9", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
    tick();
    n_checks++; if (result_valid_o !== 1'b0) $display("FAIL b2b_no_extra: got valid=%b want 0", result_valid_o); else n_pass++;
  endtask

  task automatic test_same_cycle_write();
    apply_reset();
    wr_valid_i     = 1'b1;
    wr_inval_i     = 1'b0;
    wr_index_i     = 5'd5;
    wr_data_i      = 32'hCAFE_F00D;
    search_valid_i = 1'b1;
    search_key_i   = 32'hCAFE_F00D;
    tick();
    wr_valid_i = 1'b0;
    tick();
    search_valid_i = 1'b0;
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b0 || result_index_o !== '0)
      $display("FAIL same_cycle_miss: got v=%b hit=%b idx=%0d want 1/0/0", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
    tick();
    n_checks++; if (result_valid_o !== 1'b1 || result_hit_o !== 1'b1 || result_index_o !== 5'd5)
      $display("FAIL next_cycle_hit: got v=%b hit=%b idx=%0d want 1/1/5", result_valid_o, result_hit_o, result_index_o);
    else n_pass++;
    idle();
  endtask

  task automatic test_reset_mid_flight();
    logic seen;
    apply_reset();
    do_write(1'b0, 1, 32'h0000_0055);
    result_ready_i = 1'b0;
    search_valid_i = 1'b1;
    search_key_i   = 32'h0000_0055;
    tick();
    tick();
    search_valid_i = 1'b0;
    n_checks++; if (result_valid_o !== 1'b1) $display("FAIL midrst_setup: got valid=%b want 1", result_valid_o); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (result_valid_o !== 1'b0 || count_o !== '0 || search_ready_o !== 1'b1)
      $display("FAIL midrst_async: got v=%b count=%0d ready=%b want 0/0/1", result_valid_o, count_o, search_ready_o);
    else n_pass++;
    tick();
    idle();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (result_valid_o !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL midrst_no_result: got a result after release, want none"); else n_pass++;
    n_checks++; if (count_o !== '0 || entries_o != '0)
      $display("FAIL midrst_state: got count=%0d entries_zero=%b want 0/1", count_o, entries_o == '0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] pool [4];
    logic             mvalid [DEPTH];
    logic [WIDTH-1:0] mdata  [DEPTH];
    exp_t             q[$];
    exp_t             ne;
    int               e;
    int               mcount;
    int               bad_ent;
    logic             acc;
    logic             cons;
    logic             exp_rdy;
    logic             exp_vld;
    pool[0] = 32'h0000_0000;
    pool[1] = 32'h1234_5678;
    pool[2] = 32'hA5A5_A5A5;
    pool[3] = 32'hFFFF_0001;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mvalid[i] = 1'b0;
      mdata[i]  = '0;
    end
    e = 0;
    for (int c = 0; c < 400; c++) begin
      search_valid_i = ($urandom_range(0, 3) != 0);
      search_key_i   = pool[$urandom_range(0, 3)];
      wr_valid_i     = ($urandom_range(0, 2) == 0);
      wr_inval_i     = ($urandom_range(0, 3) == 0);
      wr_index_i     = IDX_W'($urandom_range(0, 7));
      wr_data_i      = pool[$urandom_range(0, 3)];
      result_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      // Two searches outstanding means both stages are occupied.
      exp_rdy = !(q.size() == 2 && !result_ready_i);
      n_checks++; if (search_ready_o !== exp_rdy)
        $display("FAIL rnd_ready c=%0d: got %b want %b", c, search_ready_o, exp_rdy);
      else n_pass++;
      acc = search_valid_i && exp_rdy;
      ne.hit = 1'b0;
      ne.idx = '0;
      ne.acc = e + 1;
      for (int i = 0; i < DEPTH; i++) begin
        if (!ne.hit && mvalid[i] && mdata[i] == search_key_i) begin
          ne.hit = 1'b1;
          ne.idx = IDX_W'(i);
        end
      end
      cons = result_ready_i && q.size() > 0 && e >= q[0].acc + 1;
      @(posedge clk);
      e++;
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(ne);
      if (wr_valid_i) begin
        if (wr_inval_i) mvalid[wr_index_i] = 1'b0;
        else begin
          mvalid[wr_index_i] = 1'b1;
          mdata[wr_index_i]  = wr_data_i;
        end
      end
      #1;
      mcount  = 0;
      bad_ent = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (mvalid[i]) mcount++;
        if (bad_ent < 0 && entries_o[i] !== mdata[i]) bad_ent = i;
      end
      exp_vld = q.size() > 0 && e >= q[0].acc + 1;
      n_checks++; if (result_valid_o !== exp_vld)
        $display("FAIL rnd_valid c=%0d: got %b want %b", c, result_valid_o, exp_vld);
      else n_pass++;
      if (exp_vld) begin
        n_checks++; if (result_hit_o !== q[0].hit || result_index_o !== q[0].idx)
          $display("FAIL rnd_result c=%0d: got hit=%b idx=%0d want hit=%b idx=%0d",
                   c, result_hit_o, result_index_o, q[0].hit, q[0].idx);
        else n_pass++;
      end
      n_checks++; if (count_o !== (IDX_W+1)'(mcount))
        $display("FAIL rnd_count c=%0d: got %0d want %0d", c, count_o, mcount);
      else n_pass++;
      n_checks++; if (bad_ent >= 0)
        $display("FAIL rnd_entries c=%0d: entry %0d got %h want %h", c, bad_ent, entries_o[bad_ent], mdata[bad_ent]);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_hit();
    test_priority_inval();
    test_empty_miss();
    test_back_to_back();
    test_same_cycle_write();
    test_reset_mid_flight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_cam_search_engine
